// File: rtl/fft_src_pkg.sv
// rtl/fft_src_pkg.sv - shared types and constants for the FFT frame source
package fft_src_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CFG    = 2'd1,
    ST_STREAM = 2'd2
  } state_e;

  localparam int CFG_LEN_LSB  = 0;
  localparam int CFG_MODE_BIT = 16;
  localparam int MIN_LEN_M1   = 7;

  function automatic logic [15:0] clamp_len(input logic [15:0] len_m1,
                                            input logic [15:0] max_m1,
                                            input logic [15:0] min_m1);
    logic [15:0] v;
    v = (len_m1 > max_m1) ? max_m1 : len_m1;
    return (v < min_m1) ? min_m1 : v;
  endfunction

endpackage

// File: rtl/fft_src_fifo.sv
// rtl/fft_src_fifo.sv - first-word-fall-through FIFO with a registered head
module fft_src_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_AW    = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [2*DATA_WIDTH-1:0] wr_data,
  input  logic                    rd_en,
  output logic [2*DATA_WIDTH-1:0] rd_data,
  output logic [FIFO_AW:0]        level,
  output logic                    full,
  output logic                    empty
);

  localparam int DEPTH = 2**FIFO_AW;
  localparam int W     = 2*DATA_WIDTH;

  logic [W-1:0]       mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   mem_cnt_q, mem_cnt_d, level_q, level_d;
  logic [W-1:0]       head_q;
  logic               head_vld_q;
  logic               pop, wr_acc, refill, from_mem, bypass, to_mem;

  // The head register counts toward level, so the array never holds more than DEPTH-1.
  always_comb begin
    full      = (level_q == (FIFO_AW+1)'(DEPTH));
    pop       = rd_en & head_vld_q;
    wr_acc    = wr_en & (~full | pop);
    refill    = ~head_vld_q | pop;
    from_mem  = refill & (mem_cnt_q != '0);
    bypass    = refill & (mem_cnt_q == '0) & wr_acc;
    to_mem    = wr_acc & ~bypass;
    mem_cnt_d = mem_cnt_q + (FIFO_AW+1)'(to_mem) - (FIFO_AW+1)'(from_mem);
    level_d   = level_q + (FIFO_AW+1)'(wr_acc) - (FIFO_AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (to_mem) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cnt_q  <= '0;
      level_q    <= '0;
      head_q     <= '0;
      head_vld_q <= 1'b0;
    end else begin
      mem_cnt_q <= mem_cnt_d;
      level_q   <= level_d;
      if (to_mem)   wr_ptr_q <= wr_ptr_q + 1'b1;
      if (from_mem) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (from_mem) begin
        head_q     <= mem_q[rd_ptr_q];
        head_vld_q <= 1'b1;
      end else if (bypass) begin
        head_q     <= wr_data;
        head_vld_q <= 1'b1;
      end else if (pop) begin
        head_vld_q <= 1'b0;
      end
    end
  end

  assign rd_data = head_q;
  assign level   = level_q;
  assign empty   = ~head_vld_q;

endmodule

// File: rtl/fft_frame_src.sv
// rtl/fft_frame_src.sv - buffers a free-running sample stream and bursts whole frames
module fft_frame_src #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_AW    = 10,
  parameter int MIN_LEN_M1 = fft_src_pkg::MIN_LEN_M1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    fft_mode,
  input  logic [15:0]             frame_len_m1,
  input  logic                    in_valid,
  input  logic [2*DATA_WIDTH-1:0] in_data,
  output logic                    cfg_valid,
  output logic [23:0]             cfg_data,
  input  logic                    cfg_ready,
  output logic                    m_axi_valid,
  output logic                    m_axi_last,
  output logic [2*DATA_WIDTH-1:0] m_axi_data,
  input  logic                    m_axi_ready,
  output logic [FIFO_AW:0]        fifo_level,
  output logic                    ovf_flag,
  input  logic                    ovf_clr,
  output logic [15:0]             frame_cnt
);
  import fft_src_pkg::*;

  localparam logic [15:0] MAX_M1 = 16'(2**FIFO_AW - 1);
  localparam logic [15:0] MIN_M1 = 16'(MIN_LEN_M1);

  state_e                  state_q, state_d;
  logic                    mode_q, mode_d, ovf_q, ovf_d;
  logic [15:0]             len_q, len_d, cnt_q, cnt_d, frame_cnt_q, frame_cnt_d;
  logic [15:0]             len_req;
  logic [2*DATA_WIDTH-1:0] head;
  logic [FIFO_AW:0]        level;
  logic                    fifo_full, fifo_empty, launch, m_hs, wr_drop;

  fft_src_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_AW(FIFO_AW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (in_valid),
    .wr_data (in_data),
    .rd_en   (m_hs),
    .rd_data (head),
    .level   (level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    len_req     = clamp_len(frame_len_m1, MAX_M1, MIN_M1);
    launch      = enable & (17'(level) >= (17'(len_req) + 17'd1));
    cfg_valid   = (state_q == ST_CFG);
    cfg_data    = '0;
    cfg_data[CFG_LEN_LSB +: 16] = len_q;
    cfg_data[CFG_MODE_BIT]      = mode_q;
    m_axi_valid = (state_q == ST_STREAM) & ~fifo_empty;
    m_axi_last  = m_axi_valid & (cnt_q == len_q);
    m_axi_data  = m_axi_valid ? head : '0;
    m_hs        = m_axi_valid & m_axi_ready;
    // A full write survives only when the same cycle frees a slot.
    wr_drop     = in_valid & fifo_full & ~m_hs;
    ovf_d       = wr_drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          mode_d  = fft_mode;
          len_d   = len_req;
          cnt_d   = '0;
          state_d = ST_CFG;
        end
      end
      ST_CFG: begin
        if (cfg_ready) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (m_hs) begin
          cnt_d = cnt_q + 16'd1;
          if (m_axi_last) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= 1'b0;
      len_q       <= '0;
      cnt_q       <= '0;
      frame_cnt_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      frame_cnt_q <= frame_cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  assign fifo_level = level;
  assign ovf_flag   = ovf_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_fft_frame_src.sv
// tb/tb_fft_frame_src.sv - directed self-checking bench for fft_frame_src
module tb_fft_frame_src;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, fft_mode, in_valid, cfg_ready, m_axi_ready, ovf_clr;
  logic [15:0] frame_len_m1;
  logic [31:0] in_data;
  logic        cfg_valid, m_axi_valid, m_axi_last, ovf_flag;
  logic [23:0] cfg_data;
  logic [31:0] m_axi_data;
  logic [10:0] fifo_level;
  logic [15:0] frame_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fft_frame_src #(.DATA_WIDTH(16), .FIFO_AW(10), .MIN_LEN_M1(7)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .fft_mode     (fft_mode),
    .frame_len_m1 (frame_len_m1),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .cfg_valid    (cfg_valid),
    .cfg_data     (cfg_data),
    .cfg_ready    (cfg_ready),
    .m_axi_valid  (m_axi_valid),
    .m_axi_last   (m_axi_last),
    .m_axi_data   (m_axi_data),
    .m_axi_ready  (m_axi_ready),
    .fifo_level   (fifo_level),
    .ovf_flag     (ovf_flag),
    .ovf_clr      (ovf_clr),
    .frame_cnt    (frame_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_cfg_v"}, cfg_valid, 0);
    chk({tag, "_cfg_d"}, cfg_data, 0);
    chk({tag, "_m_v"}, m_axi_valid, 0);
    chk({tag, "_m_l"}, m_axi_last, 0);
    chk({tag, "_m_d"}, m_axi_data, 0);
    chk({tag, "_lvl"}, fifo_level, 0);
    chk({tag, "_ovf"}, ovf_flag, 0);
    chk({tag, "_fcnt"}, frame_cnt, 0);
  endtask

  task automatic wr_samples(input logic [31:0] base, input int n, input int exp_lvl);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("cfg_early", cfg_valid, 0);
      in_valid = 1'b1;
      in_data  = base + 32'(i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("wr_lvl", fifo_level, exp_lvl);
    chk("cfg_early", cfg_valid, 0);
  endtask

  // Waits for cfg, optionally stalls it, then drains n_take samples of an n-sample frame.
  task automatic run_frame(input logic [23:0] exp_cfg, input int n, input int n_take,
                           input logic [31:0] base, input bit toggle, input int stall,
                           input bit wr_during, input logic [31:0] wr_base);
    int w;
    int k;
    int cyc;
    bit r;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!cfg_valid && w < 50);
    chk("launch_lat", w, 1);
    chk("cfg_data", cfg_data, exp_cfg);
    for (int i = 0; i < stall; i++) begin
      cfg_ready = 1'b0;
      @(negedge clk);
      chk("cfg_hold_v", cfg_valid, 1);
      chk("cfg_hold_d", cfg_data, exp_cfg);
      chk("no_early_m", m_axi_valid, 0);
    end
    cfg_ready = 1'b1;
    @(negedge clk);
    cfg_ready = 1'b0;
    chk("cfg_done", cfg_valid, 0);
    k = 0;
    cyc = 0;
    while (k < n_take && cyc < 4*n + 20) begin
      r = toggle ? (cyc[0] == 1'b0) : 1'b1;
      m_axi_ready = r;
      in_valid    = wr_during;
      in_data     = wr_base + 32'(cyc);
      chk("m_valid", m_axi_valid, 1);
      if (m_axi_valid) begin
        chk("m_data", m_axi_data, base + 32'(k));
        chk("m_last", m_axi_last, 32'(k == n - 1));
        if (r) k++;
      end
      cyc++;
      @(negedge clk);
    end
    m_axi_ready = 1'b0;
    in_valid    = 1'b0;
    enable      = 1'b0;
    chk("take_cnt", k, n_take);
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b0; fft_mode = 1'b0; frame_len_m1 = 16'd63;
    in_valid = 1'b0; in_data = '0; cfg_ready = 1'b0; m_axi_ready = 1'b0; ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    rst_n = 1'b1;

    enable = 1'b1;
    wr_samples(32'd0, 64, 64);
    run_frame(24'h00003F, 64, 64, 32'd0, 1'b0, 0, 1'b0, 32'd0);
    chk("basic_fcnt", frame_cnt, 1);
    chk("basic_lvl", fifo_level, 0);

    enable = 1'b1;
    wr_samples(32'd100, 64, 64);
    run_frame(24'h00003F, 64, 64, 32'd100, 1'b1, 0, 1'b0, 32'd0);
    chk("bp_fcnt", frame_cnt, 2);

    enable = 1'b1;
    wr_samples(32'd200, 64, 64);
    run_frame(24'h00003F, 64, 64, 32'd200, 1'b0, 10, 1'b0, 32'd0);
    chk("stall_fcnt", frame_cnt, 3);

    fft_mode = 1'b1; frame_len_m1 = 16'd2; enable = 1'b1;
    wr_samples(32'd300, 8, 8);
    run_frame(24'h010007, 8, 8, 32'd300, 1'b0, 0, 1'b0, 32'd0);
    chk("clamp_fcnt", frame_cnt, 4);
    chk("clamp_lvl", fifo_level, 0);

    fft_mode = 1'b0; frame_len_m1 = 16'hFFFF; enable = 1'b0;
    wr_samples(32'd0, 1027, 1024);
    chk("ovf_set", ovf_flag, 1);
    in_valid = 1'b1; in_data = 32'hDEAD; ovf_clr = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; ovf_clr = 1'b0;
    chk("ovf_set_wins", ovf_flag, 1);
    chk("ovf_lvl", fifo_level, 1024);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("ovf_clr", ovf_flag, 0);
    enable = 1'b1;
    run_frame(24'h0003FF, 1024, 1024, 32'd0, 1'b0, 0, 1'b1, 32'd2000);
    chk("full_rw_ovf", ovf_flag, 0);
    chk("full_rw_lvl", fifo_level, 1024);
    chk("big_fcnt", frame_cnt, 5);

    frame_len_m1 = 16'd63; enable = 1'b1;
    run_frame(24'h00003F, 64, 20, 32'd2000, 1'b0, 0, 1'b0, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    rst_n = 1'b1;
    enable = 1'b1;
    wr_samples(32'd500, 64, 64);
    run_frame(24'h00003F, 64, 64, 32'd500, 1'b0, 0, 1'b0, 32'd0);
    chk("post_rst_fcnt", frame_cnt, 1);
    chk("post_rst_lvl", fifo_level, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
